// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the memory controller: grant, one-cycle command, wait on BUSY, ack.
// Define MEM_ARBITER_ROUND_ROBIN_EN to swap fixed port-0 priority for round-robin on contention.
module mem_arbiter #(
    parameter int ADDRESS_BITS   = 16,
    parameter int BITS           = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    req0,
    input  logic                    wr0,
    input  logic [ADDRESS_BITS-1:0] addr0,
    input  logic [BITS-1:0]         wdata0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic                    wr1,
    input  logic [ADDRESS_BITS-1:0] addr1,
    input  logic [BITS-1:0]         wdata1,
    output logic                    ack1,
    output logic [BITS-1:0]         rdata,
    output logic                    timeout,
    output logic                    grant,
    output logic [ADDRESS_BITS-1:0] memoryAddr,
    output logic [BITS-1:0]         memoryOut,
    input  logic [BITS-1:0]         memoryIn,
    output logic                    mem_RD,
    output logic                    mem_WR,
    input  logic                    BUSY
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int WD_BITS     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(WD_LAST_INT);

    logic [1:0]         state;
    logic [WD_BITS-1:0] wdCount;
    logic               isWrite;
    logic               pick;
    logic               selWr;
    logic [ADDRESS_BITS-1:0] selAddr;
    logic [BITS-1:0]    selData;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Port of the last completed transaction; resets to 1 so the first contended grant is port 0.
    logic lastDone;

    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~lastDone;
        end else begin
            pick = req1;
        end
    end
`else
    always_comb begin
        pick = ~req0;
    end
`endif

    always_comb begin
        selWr   = pick ? wr1    : wr0;
        selAddr = pick ? addr1  : addr0;
        selData = pick ? wdata1 : wdata0;
    end

    // Requester inputs are only sampled in IDLE; everything after that runs off the registered copy.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state      <= IDLE;
            wdCount    <= '0;
            isWrite    <= 1'b0;
            grant      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            timeout    <= 1'b0;
            mem_RD     <= 1'b0;
            mem_WR     <= 1'b0;
            memoryAddr <= '0;
            memoryOut  <= '0;
            rdata      <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            lastDone   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant      <= pick;
                        isWrite    <= selWr;
                        memoryAddr <= selAddr;
                        memoryOut  <= selData;
                        mem_RD     <= ~selWr;
                        mem_WR     <= selWr;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_RD <= 1'b0;
                    mem_WR <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (!BUSY) begin
                        if (!isWrite) begin
                            rdata <= memoryIn;
                        end
                        ack0  <= ~grant;
                        ack1  <= grant;
                        state <= DONE;
                    end else if (TIMEOUT_CYCLES != 0 && wdCount == WD_LAST) begin
                        timeout <= 1'b1;
                        ack0    <= ~grant;
                        ack1    <= grant;
                        state   <= DONE;
                    end else begin
                        wdCount <= wdCount + 1'b1;
                    end
                end
                DONE: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    timeout <= 1'b0;
                    wdCount <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    lastDone <= grant;
`endif
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
